alu_instr_sequencer: RTL and testbench

- Moore control FSM that sequences the Mini SRC single-bus datapath through fetch (T0-T2) and execute (T3-T5) for register-register and immediate logic/arithmetic instructions.
- Drives the register-transfer strobes that route operands through Y, the ALU (and/or/add/sub units) and Z.
- Sits between the IR and the datapath. It is the control unit for the ALU-class subset only.

---
 rtl/alu_instr_sequencer_if.sv | 45 ++++
 rtl/alu_instr_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_instr_sequencer_if.sv
// Control/status bundle between the ALU-class sequencer and the single-bus datapath.
// The sequencer side takes the master modport; the datapath/IR side takes slave.
interface alu_instr_sequencer_if #(
   parameter int COUNT_W = 16
);
   logic               run;
   logic               mem_ready;
   logic [31:0]        ir;
   logic               pc_out;
   logic               mar_in;
   logic               inc_pc;
   logic               z_in;
   logic               zlow_out;
   logic               pc_in;
   logic               read;
   logic               mdr_in;
   logic               mdr_out;
   logic               ir_in;
   logic               gra;
   logic               grb;
   logic               grc;
   logic               r_out;
   logic               r_in;
   logic               y_in;
   logic               c_out;
   logic [1:0]         alu_sel;
   logic [2:0]         state;
   logic               halted;
   logic               fault;
   logic [COUNT_W-1:0] instr_count;

   modport master (
      input  run, mem_ready, ir,
      output pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in, mdr_out, ir_in,
      output gra, grb, grc, r_out, r_in, y_in, c_out,
      output alu_sel, state, halted, fault, instr_count
   );

   modport slave (
      output run, mem_ready, ir,
      input  pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in, mdr_out, ir_in,
      input  gra, grb, grc, r_out, r_in, y_in, c_out,
      input  alu_sel, state, halted, fault, instr_count
   );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Moore control FSM for the Mini SRC single-bus datapath, ALU-class subset only:
// fetch in T0-T2, register/immediate logic and arithmetic execute in T3-T5.
//
// state | meaning
// IDLE  | waiting for run at an instruction boundary
// T0    | PC onto bus, MAR load, PC increment into Z
// T1    | Z back into PC, memory read into MDR; waits on mem_ready
// T2    | MDR into IR
// T3    | decode; Rb into Y for ALU ops, nop retires here
// T4    | Rc or immediate through the ALU into Z
// T5    | Z into Ra, retire
// HALT  | halt instruction, illegal opcode or memory timeout; only clear exits
module alu_instr_sequencer #(
   parameter int COUNT_W     = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  clock,
   input  logic                  clear,
   alu_instr_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_T5   = 3'd6,
      S_HALT = 3'd7
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam int              TMO_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

   state_t             state_q, state_nxt;
   logic               fault_q;
   logic [COUNT_W-1:0] count_q;
   logic [TMO_W-1:0]   tmo_q;
   logic               set_fault;
   logic               retire;
   logic [4:0]         opcode;
   logic               is_reg, is_imm, is_nop, is_halt;
   logic [1:0]         sel_dec;
   logic               unused_ir;

   assign opcode    = bus.ir[31:27];
   assign unused_ir = ^bus.ir[26:0];

   assign is_reg  = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) || (opcode == OP_OR);
   assign is_imm  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
   assign is_nop  = (opcode == OP_NOP);
   assign is_halt = (opcode == OP_HALT);

   always_comb begin
      sel_dec = 2'd0;
      case (opcode)
         OP_SUB:          sel_dec = 2'd1;
         OP_AND, OP_ANDI: sel_dec = 2'd2;
         OP_OR,  OP_ORI:  sel_dec = 2'd3;
         default:         sel_dec = 2'd0;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= S_IDLE;
         fault_q <= 1'b0;
         count_q <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_nxt;
         if (set_fault) fault_q <= 1'b1;
         if (retire)    count_q <= count_q + 1'b1;
         // Counts only stalled T1 cycles; any other state leaves it at zero for the next entry.
         if (state_q == S_T1 && !bus.mem_ready) tmo_q <= tmo_q + 1'b1;
         else                                    tmo_q <= '0;
      end
   end

   always_comb begin
      state_nxt    = state_q;
      set_fault    = 1'b0;
      retire       = 1'b0;
      bus.pc_out   = 1'b0;
      bus.mar_in   = 1'b0;
      bus.inc_pc   = 1'b0;
      bus.z_in     = 1'b0;
      bus.zlow_out = 1'b0;
      bus.pc_in    = 1'b0;
      bus.read     = 1'b0;
      bus.mdr_in   = 1'b0;
      bus.mdr_out  = 1'b0;
      bus.ir_in    = 1'b0;
      bus.gra      = 1'b0;
      bus.grb      = 1'b0;
      bus.grc      = 1'b0;
      bus.r_out    = 1'b0;
      bus.r_in     = 1'b0;
      bus.y_in     = 1'b0;
      bus.c_out    = 1'b0;
      bus.alu_sel  = 2'd0;
      case (state_q)
         S_IDLE: if (bus.run) state_nxt = S_T0;
         S_T0: begin
            bus.pc_out = 1'b1;
            bus.mar_in = 1'b1;
            bus.inc_pc = 1'b1;
            bus.z_in   = 1'b1;
            state_nxt  = S_T1;
         end
         S_T1: begin
            bus.zlow_out = 1'b1;
            bus.pc_in    = 1'b1;
            bus.read     = 1'b1;
            bus.mdr_in   = 1'b1;
            if (bus.mem_ready) begin
               state_nxt = S_T2;
            end else if (tmo_q == TMO_LAST) begin
               state_nxt = S_HALT;
               set_fault = 1'b1;
            end
         end
         S_T2: begin
            bus.mdr_out = 1'b1;
            bus.ir_in   = 1'b1;
            state_nxt   = S_T3;
         end
         S_T3: begin
            if (is_reg || is_imm) begin
               bus.grb   = 1'b1;
               bus.r_out = 1'b1;
               bus.y_in  = 1'b1;
               state_nxt = S_T4;
            end else if (is_nop) begin
               retire    = 1'b1;
               state_nxt = bus.run ? S_T0 : S_IDLE;
            end else if (is_halt) begin
               state_nxt = S_HALT;
            end else begin
               state_nxt = S_HALT;
               set_fault = 1'b1;
            end
         end
         S_T4: begin
            bus.z_in    = 1'b1;
            bus.alu_sel = sel_dec;
            // Immediate forms put the sign-extended C field on the bus in place of Rc.
            if (is_imm) begin
               bus.c_out = 1'b1;
            end else begin
               bus.grc   = 1'b1;
               bus.r_out = 1'b1;
            end
            state_nxt = S_T5;
         end
         S_T5: begin
            bus.zlow_out = 1'b1;
            bus.gra      = 1'b1;
            bus.r_in     = 1'b1;
            retire       = 1'b1;
            state_nxt    = bus.run ? S_T0 : S_IDLE;
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.state       = state_q;
   assign bus.halted      = (state_q == S_HALT);
   assign bus.fault       = fault_q;
   assign bus.instr_count = count_q;
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench: each step's inputs and expected state/strobes/status are queued
// up front, then replayed one clock at a time and compared against the DUT.
module tb_alu_instr_sequencer;
   localparam int CW = 4;

   localparam logic [16:0] PC_OUT   = 17'h10000;
   localparam logic [16:0] MAR_IN   = 17'h08000;
   localparam logic [16:0] INC_PC   = 17'h04000;
   localparam logic [16:0] Z_IN     = 17'h02000;
   localparam logic [16:0] ZLOW_OUT = 17'h01000;
   localparam logic [16:0] PC_IN    = 17'h00800;
   localparam logic [16:0] READ     = 17'h00400;
   localparam logic [16:0] MDR_IN   = 17'h00200;
   localparam logic [16:0] MDR_OUT  = 17'h00100;
   localparam logic [16:0] IR_IN    = 17'h00080;
   localparam logic [16:0] GRA      = 17'h00040;
   localparam logic [16:0] GRB      = 17'h00020;
   localparam logic [16:0] GRC      = 17'h00010;
   localparam logic [16:0] R_OUT    = 17'h00008;
   localparam logic [16:0] R_IN     = 17'h00004;
   localparam logic [16:0] Y_IN     = 17'h00002;
   localparam logic [16:0] C_OUT    = 17'h00001;

   localparam logic [31:0] I_ADD  = 32'h18000000;
   localparam logic [31:0] I_SUB  = 32'h20000000;
   localparam logic [31:0] I_AND  = 32'h28918000;
   localparam logic [31:0] I_OR   = 32'h30000000;
   localparam logic [31:0] I_ADDI = 32'h60000000;
   localparam logic [31:0] I_ANDI = 32'h68000005;
   localparam logic [31:0] I_ORI  = 32'h70000000;
   localparam logic [31:0] I_ILL  = 32'h78000000;
   localparam logic [31:0] I_NOP  = 32'hD0000000;
   localparam logic [31:0] I_HALT = 32'hD8000000;

   typedef struct packed {
      logic [31:0] ir;
      logic        run;
      logic        mr;
      logic [27:0] exp;
   } step_t;

   logic clock;
   logic clear;
   alu_instr_sequencer_if #(.COUNT_W(CW)) sif ();

   alu_instr_sequencer #(.COUNT_W(CW), .MEM_TIMEOUT(15)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (sif.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   step_t   sb[$];
   string   tags[$];
   int      checks = 0;
   int      passes = 0;
   int      fails  = 0;
   logic [CW-1:0] exp_cnt = '0;
   logic    exp_fault = 1'b0;

   function automatic logic [27:0] observe();
      return {sif.state, sif.halted, sif.fault,
              sif.pc_out, sif.mar_in, sif.inc_pc, sif.z_in, sif.zlow_out, sif.pc_in,
              sif.read, sif.mdr_in, sif.mdr_out, sif.ir_in, sif.gra, sif.grb, sif.grc,
              sif.r_out, sif.r_in, sif.y_in, sif.c_out, sif.alu_sel, sif.instr_count};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] ir, input logic run, input logic mr,
                       input logic [2:0] st, input logic [16:0] stb, input logic [1:0] sel);
      step_t e;
      e.ir  = ir;
      e.run = run;
      e.mr  = mr;
      e.exp = {st, (st == 3'd7), exp_fault, stb, sel, exp_cnt};
      sb.push_back(e);
      tags.push_back(tag);
   endtask

   task automatic fetch(input logic [31:0] ir, input int stalls);
      push("t0", ir, 1'b1, 1'b1, 3'd1, PC_OUT | MAR_IN | INC_PC | Z_IN, 2'd0);
      for (int i = 0; i < stalls; i++)
         push("t1_stall", ir, 1'b0, 1'b0, 3'd2, ZLOW_OUT | PC_IN | READ | MDR_IN, 2'd0);
      push("t1", ir, 1'b0, 1'b1, 3'd2, ZLOW_OUT | PC_IN | READ | MDR_IN, 2'd0);
      push("t2", ir, 1'b0, 1'b1, 3'd3, MDR_OUT | IR_IN, 2'd0);
   endtask

   task automatic alu_op(input logic [31:0] ir, input int stalls, input logic [1:0] sel,
                         input bit imm, input logic run_t4, input logic run_end);
      fetch(ir, stalls);
      push("t3_alu", ir, 1'b1, 1'b1, 3'd4, GRB | R_OUT | Y_IN, 2'd0);
      push("t4_alu", ir, run_t4, 1'b1, 3'd5, imm ? (Z_IN | C_OUT) : (Z_IN | GRC | R_OUT), sel);
      push("t5_alu", ir, run_end, 1'b1, 3'd6, ZLOW_OUT | GRA | R_IN, 2'd0);
      exp_cnt++;
   endtask

   task automatic nop_op(input logic run_end);
      fetch(I_NOP, 0);
      push("t3_nop", I_NOP, run_end, 1'b1, 3'd4, 17'd0, 2'd0);
      exp_cnt++;
   endtask

   task automatic stop_op(input logic [31:0] ir, input bit illegal);
      fetch(ir, 0);
      push("t3_stop", ir, 1'b1, 1'b1, 3'd4, 17'd0, 2'd0);
      if (illegal) exp_fault = 1'b1;
      for (int i = 0; i < 3; i++) push("halt_hold", ir, 1'b1, 1'b1, 3'd7, 17'd0, 2'd0);
   endtask

   task automatic drain();
      step_t e;
      string t;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         t = tags.pop_front();
         sif.ir        = e.ir;
         sif.run       = e.run;
         sif.mem_ready = e.mr;
         #1;
         check(t, {4'd0, observe()}, {4'd0, e.exp});
         check("bus_excl", {31'd0, $onehot0({sif.r_out, sif.c_out, sif.zlow_out, sif.pc_out, sif.mdr_out})}, 32'd1);
         @(negedge clock);
      end
   endtask

   // Assert clear between clock edges and confirm the outputs drop without waiting for a clock.
   task automatic clear_pulse();
      sif.run = 1'b0;
      #2 clear = 1'b1;
      #1 check("clear_async", {4'd0, observe()}, 32'd0);
      #1 clear = 1'b0;
      exp_cnt   = '0;
      exp_fault = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      clear         = 1'b1;
      sif.run       = 1'b0;
      sif.mem_ready = 1'b0;
      sif.ir        = 32'd0;
      repeat (2) @(negedge clock);
      clear = 1'b0;

      push("reset_idle", 32'd0, 1'b0, 1'b0, 3'd0, 17'd0, 2'd0);
      push("idle_go", 32'd0, 1'b1, 1'b1, 3'd0, 17'd0, 2'd0);
      alu_op(I_AND, 0, 2'd2, 1'b0, 1'b1, 1'b1);
      alu_op(I_ADD, 3, 2'd0, 1'b0, 1'b1, 1'b1);
      alu_op(I_ANDI, 0, 2'd2, 1'b1, 1'b1, 1'b1);
      nop_op(1'b1);
      alu_op(I_SUB, 0, 2'd1, 1'b0, 1'b1, 1'b1);
      alu_op(I_ADDI, 1, 2'd0, 1'b1, 1'b1, 1'b1);
      alu_op(I_ORI, 0, 2'd3, 1'b1, 1'b1, 1'b1);
      alu_op(I_OR, 0, 2'd3, 1'b0, 1'b0, 1'b0);
      push("idle_stay", I_OR, 1'b0, 1'b1, 3'd0, 17'd0, 2'd0);
      push("idle_stay", I_OR, 1'b0, 1'b1, 3'd0, 17'd0, 2'd0);
      push("idle_go", I_OR, 1'b1, 1'b0, 3'd0, 17'd0, 2'd0);
      push("t0_tmo", I_ADD, 1'b1, 1'b0, 3'd1, PC_OUT | MAR_IN | INC_PC | Z_IN, 2'd0);
      for (int i = 0; i < 15; i++)
         push("t1_tmo", I_ADD, 1'b1, 1'b0, 3'd2, ZLOW_OUT | PC_IN | READ | MDR_IN, 2'd0);
      exp_fault = 1'b1;
      for (int i = 0; i < 3; i++) push("halt_tmo", I_ADD, 1'b1, 1'b0, 3'd7, 17'd0, 2'd0);
      drain();
      clear_pulse();

      push("idle_go", I_ILL, 1'b1, 1'b1, 3'd0, 17'd0, 2'd0);
      stop_op(I_ILL, 1'b1);
      drain();
      clear_pulse();

      push("idle_go", I_HALT, 1'b1, 1'b1, 3'd0, 17'd0, 2'd0);
      stop_op(I_HALT, 1'b0);
      drain();
      clear_pulse();

      push("idle_go", I_ADD, 1'b1, 1'b0, 3'd0, 17'd0, 2'd0);
      push("t0_abort", I_ADD, 1'b1, 1'b0, 3'd1, PC_OUT | MAR_IN | INC_PC | Z_IN, 2'd0);
      push("t1_abort", I_ADD, 1'b1, 1'b0, 3'd2, ZLOW_OUT | PC_IN | READ | MDR_IN, 2'd0);
      push("t1_abort", I_ADD, 1'b1, 1'b0, 3'd2, ZLOW_OUT | PC_IN | READ | MDR_IN, 2'd0);
      drain();
      clear_pulse();
      push("idle_after_abort", I_ADD, 1'b0, 1'b1, 3'd0, 17'd0, 2'd0);

      push("idle_go", I_NOP, 1'b1, 1'b1, 3'd0, 17'd0, 2'd0);
      for (int i = 0; i < 16; i++) nop_op(1'b1);
      push("t0_wrapped", I_NOP, 1'b0, 1'b1, 3'd1, PC_OUT | MAR_IN | INC_PC | Z_IN, 2'd0);
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
